// File: rtl/peripheral_int_gateway.sv
// Conditions raw peripheral interrupt lines into per-source pending/in-service
// requests for the core interrupt controller (one irq_out bit per mcause 16+i),
// with a claim/complete register handshake for software.
//
// Ports:
//   clk, rst_n                  core clock, synchronous active-low reset
//   src_irq[NUM_SRC]            raw asynchronous source lines, active-high
//   reg_req/reg_we/reg_addr/    register access strobe (1 cycle), 1=write,
//   reg_wdata                   word offset, write data
//   reg_rdata/reg_ready         read data + 1-cycle response pulse (N+1)
//   irq_out[NUM_SRC], any_irq   registered requests and their OR
//
// Register map (word offset): 0 ENABLE, 1 EDGE, 2 PENDING (W1C edge bits),
// 3 CLAIM (read=claim, write=complete), 4 INSVC, 5..7 read 0.
//
// Optional feature macro: INTGW_GLITCH_FILTER_EN -- level-mode sources must be
// stable for 4 consecutive synchronized cycles before their level is used.
//
// Per-source state IDLE/PEND/INSVC is encoded by the (pending, in_service)
// bit pair rather than a separate state vector.

module peripheral_int_gateway #(
  parameter int NUM_SRC     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               reg_req,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ready,
  output logic [NUM_SRC-1:0] irq_out,
  output logic               any_irq
);

  localparam logic [2:0] A_ENABLE  = 3'd0;
  localparam logic [2:0] A_EDGE    = 3'd1;
  localparam logic [2:0] A_PENDING = 3'd2;
  localparam logic [2:0] A_CLAIM   = 3'd3;
  localparam logic [2:0] A_INSVC   = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] synced, prev_q, rise, lvl;
  logic [NUM_SRC-1:0] en_q, edge_q, pend_edge_q, insvc_q;

  logic [NUM_SRC-1:0] en_n, edge_n, pend_edge_n, insvc_n, irq_n;
  logic [NUM_SRC-1:0] pend_cur, cand, claim_oh, claim_do, cmp_hit, cmp_clr, w1c, edge_chg;
  logic [31:0]        claim_id, rdata_n;
  logic               wr, rd;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

`ifdef INTGW_GLITCH_FILTER_EN
  // Filtered level only flips once the last four synced samples agree.
  logic [NUM_SRC-1:0][3:0] hist_q;
  logic [NUM_SRC-1:0]      filt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        hist_q[i] <= {hist_q[i][2:0], synced[i]};
        if (&hist_q[i])
          filt_q[i] <= 1'b1;
        else if (~|hist_q[i])
          filt_q[i] <= 1'b0;
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = synced;
`endif

  always_comb begin
    wr       = reg_req & reg_we;
    rd       = reg_req & ~reg_we;

    // Level sources are never latched; only edge sources hold a pending flop.
    pend_cur = (edge_q & pend_edge_q) | (~edge_q & lvl & ~insvc_q);
    cand     = pend_cur & en_q & ~insvc_q;

    // Ascending scan so the highest-index candidate is the one left standing.
    claim_oh = '0;
    claim_id = '0;
    cmp_hit  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i]) begin
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
        claim_id    = 32'(i + 1);
      end
      cmp_hit[i] = (reg_wdata == 32'(i + 1));
    end

    claim_do = (rd && reg_addr == A_CLAIM) ? claim_oh : '0;
    cmp_clr  = (wr && reg_addr == A_CLAIM) ? (cmp_hit & insvc_q) : '0;
    w1c      = (wr && reg_addr == A_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;

    en_n     = (wr && reg_addr == A_ENABLE) ? reg_wdata[NUM_SRC-1:0] : en_q;
    edge_n   = (wr && reg_addr == A_EDGE)   ? reg_wdata[NUM_SRC-1:0] : edge_q;
    edge_chg = edge_q ^ edge_n;

    // A new edge beats a claim/W1C in the same cycle; a mode change always clears.
    pend_edge_n = ((pend_edge_q & ~w1c & ~claim_do) | (rise & edge_q)) & edge_n & ~edge_chg;
    insvc_n     = (insvc_q | claim_do) & ~cmp_clr;
    irq_n       = ((edge_n & pend_edge_n) | (~edge_n & lvl & ~insvc_n)) & en_n & ~insvc_n;

    rdata_n = '0;
    if (rd) begin
      case (reg_addr)
        A_ENABLE:  rdata_n[NUM_SRC-1:0] = en_q;
        A_EDGE:    rdata_n[NUM_SRC-1:0] = edge_q;
        A_PENDING: rdata_n[NUM_SRC-1:0] = pend_cur;
        A_CLAIM:   rdata_n              = claim_id;
        A_INSVC:   rdata_n[NUM_SRC-1:0] = insvc_q;
        default:   rdata_n              = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      en_q        <= '0;
      edge_q      <= '0;
      pend_edge_q <= '0;
      insvc_q     <= '0;
      irq_out     <= '0;
      reg_rdata   <= '0;
      reg_ready   <= 1'b0;
    end else begin
      sync_q[0] <= src_irq;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      prev_q      <= synced;
      en_q        <= en_n;
      edge_q      <= edge_n;
      pend_edge_q <= pend_edge_n;
      insvc_q     <= insvc_n;
      irq_out     <= irq_n;
      reg_rdata   <= rdata_n;
      reg_ready   <= reg_req;
    end
  end

  assign any_irq = |irq_out;

endmodule

// File: tb/tb_peripheral_int_gateway.sv
// Self-checking bench for peripheral_int_gateway: register reads are scored
// through an expected-response queue drained by a monitor on reg_ready;
// irq_out is checked directly at known cycle offsets.
module tb_peripheral_int_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src_irq;
  logic        reg_req;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic [15:0] irq_out;
  logic        any_irq;

  peripheral_int_gateway #(.NUM_SRC(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_irq   (src_irq),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .irq_out   (irq_out),
    .any_irq   (any_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every reg_ready must match a queued request, reads compare data.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got reg_ready=1 expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) chk(e.name, reg_rdata, e.dat);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic access(input bit we, input logic [2:0] addr, input logic [31:0] wd,
                        input logic [31:0] want, input string name);
    exp_t e;
    @(posedge clk); #1;
    reg_req = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = wd;
    e.chk = !we; e.dat = want; e.name = name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reg_req = 1'b0; reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
    access(1'b1, addr, wd, 32'h0, "write");
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] want, input string name);
    access(1'b0, addr, 32'h0, want, name);
  endtask

  task automatic pulse(input logic [15:0] m);
    @(posedge clk); #1;
    src_irq = src_irq | m;
    step(1);
    src_irq = src_irq & ~m;
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src_irq = 16'hFFFF; reg_req = 1'b0; reg_we = 1'b0;
    reg_addr = '0; reg_wdata = '0;

    // 1 Reset
    step(3);
    chk("rst_irq_out", {16'h0, irq_out}, 32'h0);
    chk("rst_any_irq", {31'h0, any_irq}, 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    chk("rst_ready", {31'h0, reg_ready}, 32'h0);
    src_irq = 16'h0;
    rst_n   = 1'b1;
    step(3);

    // 2 Level path with exact synchronizer latency
    wr(3'd0, 32'h0004);
    wr(3'd1, 32'h0000);
    rd(3'd0, 32'h0004, "enable_rb");
    src_irq[2] = 1'b1;
`ifndef INTGW_GLITCH_FILTER_EN
    step(2);
    chk("lvl_lat_early", {16'h0, irq_out}, 32'h0);
    step(1);
`else
    step(8);
`endif
    chk("lvl_irq", {16'h0, irq_out}, 32'h0004);
    chk("lvl_any", {31'h0, any_irq}, 32'h1);
    rd(3'd3, 32'd3, "lvl_claim");
    chk("lvl_irq_claimed", {16'h0, irq_out}, 32'h0);
    rd(3'd4, 32'h0004, "lvl_insvc");
    rd(3'd2, 32'h0000, "lvl_pend_insvc");
    wr(3'd3, 32'd3);
    chk("lvl_irq_complete", {16'h0, irq_out}, 32'h0004);
    rd(3'd4, 32'h0, "lvl_insvc_clr");
    src_irq[2] = 1'b0;
    step(8);
    chk("lvl_irq_drop", {16'h0, irq_out}, 32'h0);

    // 3 Edge re-arm and W1C on an edge source
    wr(3'd1, 32'h0001);
    wr(3'd0, 32'h0001);
    pulse(16'h0001);
    chk("edge_irq", {16'h0, irq_out}, 32'h0001);
    rd(3'd3, 32'd1, "edge_claim");
    chk("edge_irq_claimed", {16'h0, irq_out}, 32'h0);
    pulse(16'h0001);
    rd(3'd2, 32'h0001, "edge_rearm_pend");
    chk("edge_rearm_irq", {16'h0, irq_out}, 32'h0);
    wr(3'd3, 32'd1);
    chk("edge_complete_irq", {16'h0, irq_out}, 32'h0001);
    wr(3'd2, 32'h0001);
    chk("edge_w1c_irq", {16'h0, irq_out}, 32'h0);
    rd(3'd2, 32'h0, "edge_w1c_pend");

    // 4 Priority
    wr(3'd1, 32'h0222);
    wr(3'd0, 32'h0222);
    pulse(16'h0222);
    rd(3'd2, 32'h0222, "prio_pend");
    chk("prio_irq", {16'h0, irq_out}, 32'h0222);
    rd(3'd3, 32'd10, "prio_claim1");
    rd(3'd3, 32'd6, "prio_claim2");
    rd(3'd3, 32'd2, "prio_claim3");
    rd(3'd3, 32'd0, "prio_claim_none");
    chk("prio_irq_all_insvc", {16'h0, irq_out}, 32'h0);
    rd(3'd4, 32'h0222, "prio_insvc");

    // 5 Bad completes, then good ones
    wr(3'd3, 32'd0);
    rd(3'd4, 32'h0222, "bad_cmp_0");
    wr(3'd3, 32'd17);
    rd(3'd4, 32'h0222, "bad_cmp_17");
    wr(3'd3, 32'd1);
    rd(3'd4, 32'h0222, "bad_cmp_not_insvc");
    wr(3'd3, 32'd10);
    wr(3'd3, 32'd6);
    wr(3'd3, 32'd2);
    rd(3'd4, 32'h0, "good_cmp_all");

    // W1C on a level source, ENABLE masking, reserved/unused bits
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h0010);
    src_irq[4] = 1'b1;
    step(8);
    rd(3'd2, 32'h0010, "w1c_lvl_before");
    wr(3'd2, 32'h0010);
    rd(3'd2, 32'h0010, "w1c_lvl_after");
    chk("w1c_lvl_irq", {16'h0, irq_out}, 32'h0010);
    wr(3'd0, 32'h0);
    chk("mask_irq", {16'h0, irq_out}, 32'h0);
    rd(3'd2, 32'h0010, "mask_pend_kept");
    src_irq[4] = 1'b0;
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0000_FFFF, "enable_upper_bits");
    rd(3'd5, 32'h0, "reserved_read");
    wr(3'd0, 32'h0);

`ifdef INTGW_GLITCH_FILTER_EN
    // 6 Glitch filter
    wr(3'd0, 32'h0008);
    @(posedge clk); #1;
    src_irq[3] = 1'b1; step(2); src_irq[3] = 1'b0;
    step(12);
    chk("filt_glitch", {16'h0, irq_out}, 32'h0);
    src_irq[3] = 1'b1; step(5); src_irq[3] = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (irq_out[3]) seen = 1'b1;
        step(1);
      end
      chk("filt_pulse", {31'h0, seen}, 32'h1);
    end
`endif

    step(3);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
